// File: rtl/adc_input_parallel_mc.sv
// adc_input_parallel_mc
//   Multi-channel parallel ADC front end. It divides aclk to produce the ADC
//   conversion clock and steps the ADC channel select round-robin. Each
//   conversion is sampled on a fixed divider phase, formatted to the stream
//   width and queued in a FIFO. The FIFO feeds a registered AXI-Stream master
//   with first-word-fall-through behaviour.
//
// Ports
//   aclk, areset            system clock, asynchronous active-high reset
//   ce                      capture enable; 0 freezes the divider, FIFO still drains
//   adc_clk                 registered ADC conversion clock
//   adc_channel_sel         channel currently presented to the ADC mux
//   adc_data                ADC parallel data
//   t*_m_out / tready_m_in  AXI-Stream master (tid = channel, tlast = last channel)
//   overflow / clr_overflow sticky sample-drop flag and its clear
//   fifo_level              FIFO entries plus the output register
module adc_input_parallel_mc #(
  parameter int    DW_ADC     = 10,
  parameter int    DW_BUS     = 16,
  parameter string FILL       = "MSB",
  parameter int    N_CH       = 2,
  parameter int    CLK_DIV    = 4,
  parameter int    CAP_PHASE  = 3,
  parameter int    FIFO_DEPTH = 16,
  parameter int    TWOS_COMP  = 0,
  localparam int   ID_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int   LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                ce,
  output logic                adc_clk,
  output logic [ID_W-1:0]     adc_channel_sel,
  input  logic [DW_ADC-1:0]   adc_data,
  output logic [DW_BUS-1:0]   tdata_m_out,
  output logic [DW_BUS/8-1:0] tstrb_m_out,
  output logic [ID_W-1:0]     tid_m_out,
  output logic                tlast_m_out,
  output logic                tvalid_m_out,
  input  logic                tready_m_in,
  output logic                overflow,
  input  logic                clr_overflow,
  output logic [LVL_W-1:0]    fifo_level
);

  localparam int  AW       = $clog2(FIFO_DEPTH);
  localparam int  DIV_W    = $clog2(CLK_DIV);
  localparam int  MEM_W    = ID_W + DW_BUS;
  localparam bit  FILL_MSB = (FILL == "MSB");

  // Divider / channel / capture stage
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              adc_clk_q, adc_clk_d;
  logic [ID_W-1:0]   chan_q, chan_d;
  logic              cap_vld_q, cap_vld_d;
  logic [DW_ADC-1:0] cap_data_q, cap_data_d;
  logic [ID_W-1:0]   cap_tag_q, cap_tag_d;
  logic              div_wrap;

  // FIFO
  logic [MEM_W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  cnt_q, cnt_d;
  logic              fifo_full, fifo_empty, push, pop, drop;
  logic [MEM_W-1:0]  rd_data;

  // Output register and status
  logic              out_vld_q, out_vld_d;
  logic [DW_BUS-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   out_tag_q, out_tag_d;
  logic              out_last_q, out_last_d;
  logic              ovf_q, ovf_d;

  // Formatting
  logic [DW_ADC-1:0] sample;
  logic [DW_BUS-1:0] fmt_word;

  assign div_wrap = (div_cnt_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    div_cnt_d  = div_cnt_q;
    adc_clk_d  = 1'b0;
    chan_d     = chan_q;
    cap_vld_d  = 1'b0;
    cap_data_d = cap_data_q;
    cap_tag_d  = cap_tag_q;
    if (ce) begin
      div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
      adc_clk_d = (div_cnt_q < DIV_W'(CLK_DIV / 2));
      if (div_cnt_q == DIV_W'(CAP_PHASE)) begin
        cap_vld_d  = 1'b1;
        cap_data_d = adc_data;
        cap_tag_d  = chan_q;
      end
      if (div_wrap && (N_CH > 1)) begin
        chan_d = (chan_q == ID_W'(N_CH - 1)) ? '0 : chan_q + 1'b1;
      end
    end
  end

  always_comb begin
    sample = cap_data_q;
    if (TWOS_COMP != 0) sample[DW_ADC-1] = ~cap_data_q[DW_ADC-1];
    if (FILL_MSB) begin
      fmt_word = DW_BUS'(sample) << (DW_BUS - DW_ADC);
    end else if (TWOS_COMP != 0) begin
      fmt_word = DW_BUS'($signed(sample));
    end else begin
      fmt_word = DW_BUS'(sample);
    end
  end

  // Full is judged on the registered count, so a same-cycle pop never makes
  // room for the incoming write.
  assign fifo_full  = (cnt_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = cap_vld_q && !fifo_full;
  assign drop       = cap_vld_q && fifo_full;
  assign pop        = !fifo_empty && (!out_vld_q || tready_m_in);
  assign rd_data    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d      = cnt_q + LVL_W'(push) - LVL_W'(pop);
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    out_last_d = out_last_q;
    // Refill on the same edge as a transfer so back-to-back words have no bubble.
    if (pop) begin
      out_vld_d  = 1'b1;
      out_data_d = rd_data[DW_BUS-1:0];
      out_tag_d  = rd_data[MEM_W-1 -: ID_W];
      out_last_d = (rd_data[MEM_W-1 -: ID_W] == ID_W'(N_CH - 1));
    end else if (tready_m_in) begin
      out_vld_d  = 1'b0;
    end
    ovf_d = ovf_q;
    if (clr_overflow) ovf_d = 1'b0;
    if (drop)         ovf_d = 1'b1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      div_cnt_q  <= '0;
      adc_clk_q  <= 1'b0;
      chan_q     <= '0;
      cap_vld_q  <= 1'b0;
      cap_data_q <= '0;
      cap_tag_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
      out_last_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      adc_clk_q  <= adc_clk_d;
      chan_q     <= chan_d;
      cap_vld_q  <= cap_vld_d;
      cap_data_q <= cap_data_d;
      cap_tag_q  <= cap_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
      out_last_q <= out_last_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= {cap_tag_q, fmt_word};
  end

  assign adc_clk         = adc_clk_q;
  assign adc_channel_sel = chan_q;
  assign tdata_m_out     = out_data_q;
  assign tstrb_m_out     = {(DW_BUS/8){out_vld_q}};
  assign tid_m_out       = out_tag_q;
  assign tlast_m_out     = out_last_q;
  assign tvalid_m_out    = out_vld_q;
  assign overflow        = ovf_q;
  assign fifo_level      = cnt_q + LVL_W'(out_vld_q);

endmodule

// File: tb/tb_adc_input_parallel_mc.sv
module tb_adc_input_parallel_mc;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Instance A: N_CH=2, FILL=MSB, offset binary
  logic        a_rst, a_ce, a_tready, a_clr;
  logic [9:0]  a_data;
  logic        a_adc_clk, a_tlast, a_tvalid, a_ovf;
  logic [0:0]  a_sel, a_tid;
  logic [15:0] a_tdata;
  logic [1:0]  a_tstrb;
  logic [4:0]  a_level;

  // Instance B: N_CH=4, FILL=LSB, two's complement
  logic        b_rst, b_ce, b_tready, b_clr;
  logic [9:0]  b_data;
  logic        b_adc_clk, b_tlast, b_tvalid, b_ovf;
  logic [1:0]  b_sel, b_tid;
  logic [15:0] b_tdata;
  logic [1:0]  b_tstrb;
  logic [4:0]  b_level;

  adc_input_parallel_mc #(.N_CH(2)) u_a (
    .aclk(aclk), .areset(a_rst), .ce(a_ce), .adc_clk(a_adc_clk),
    .adc_channel_sel(a_sel), .adc_data(a_data), .tdata_m_out(a_tdata),
    .tstrb_m_out(a_tstrb), .tid_m_out(a_tid), .tlast_m_out(a_tlast),
    .tvalid_m_out(a_tvalid), .tready_m_in(a_tready), .overflow(a_ovf),
    .clr_overflow(a_clr), .fifo_level(a_level)
  );

  adc_input_parallel_mc #(.N_CH(4), .FILL("LSB"), .TWOS_COMP(1)) u_b (
    .aclk(aclk), .areset(b_rst), .ce(b_ce), .adc_clk(b_adc_clk),
    .adc_channel_sel(b_sel), .adc_data(b_data), .tdata_m_out(b_tdata),
    .tstrb_m_out(b_tstrb), .tid_m_out(b_tid), .tlast_m_out(b_tlast),
    .tvalid_m_out(b_tvalid), .tready_m_in(b_tready), .overflow(b_ovf),
    .clr_overflow(b_clr), .fifo_level(b_level)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] a_q[$];
  logic [31:0] b_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] pk(input int tid, input bit last, input logic [15:0] d);
    return {11'd0, 4'(tid), last, d};
  endfunction

  // LSB fill, offset binary -> two's complement, sign-extended to 16 bits
  function automatic logic [31:0] exp_b(input int k);
    logic [9:0]  x;
    logic [15:0] y;
    x = 10'(k);
    y = {{6{~x[9]}}, ~x[9], x[8:0]};
    return pk(k % 4, (k % 4) == 3, y);
  endfunction

  // Record every handshake; inputs change at posedge+1, so negedge is stable.
  always @(negedge aclk) begin
    if (!a_rst && a_tvalid && a_tready) a_q.push_back(pk(int'(a_tid), a_tlast, a_tdata));
    if (!b_rst && b_tvalid && b_tready) b_q.push_back(pk(int'(b_tid), b_tlast, b_tdata));
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic reset_a();
    a_rst = 1'b1; a_ce = 1'b0; a_tready = 1'b0; a_clr = 1'b0; a_data = '0;
    step(); step();
    a_rst = 1'b0;
    step();
    a_q.delete();
  endtask

  task automatic reset_b();
    b_rst = 1'b1; b_ce = 1'b0; b_tready = 1'b0; b_clr = 1'b0; b_data = '0;
    step(); step();
    b_rst = 1'b0;
    step();
    b_q.delete();
  endtask

  task automatic wait_a(input int n, input int budget, input string tag);
    int k = 0;
    while (a_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(a_q.size()), 32'(n));
  endtask

  function automatic logic [31:0] a_word(input int i);
    return (i < a_q.size()) ? a_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] b_word(input int i);
    return (i < b_q.size()) ? b_q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int          first_v;
    logic [7:0]  pat;
    logic        clk_seen, sel_bad;
    int          n, cyc, lim;
    logic [31:0] w;

    a_rst = 1'b1; a_ce = 1'b0; a_tready = 1'b0; a_clr = 1'b0; a_data = '0;
    b_rst = 1'b1; b_ce = 1'b0; b_tready = 1'b0; b_clr = 1'b0; b_data = '0;
    step(); step(); step();

    // Reset state
    check("rst_tvalid",  32'(a_tvalid),  32'd0);
    check("rst_tdata",   32'(a_tdata),   32'd0);
    check("rst_tstrb",   32'(a_tstrb),   32'd0);
    check("rst_tid",     32'(a_tid),     32'd0);
    check("rst_tlast",   32'(a_tlast),   32'd0);
    check("rst_ovf",     32'(a_ovf),     32'd0);
    check("rst_level",   32'(a_level),   32'd0);
    check("rst_adc_clk", 32'(a_adc_clk), 32'd0);
    check("rst_sel",     32'(a_sel),     32'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    step();

    // Ramp 1,2,3,4 with tready=1
    a_tready = 1'b1;
    first_v = -1;
    pat = '0;
    for (int c = 0; c < 22; c++) begin
      if (c >= 1 && c <= 8) pat = {pat[6:0], a_adc_clk};
      if (c == 4) check("sel_after_wrap", 32'(a_sel), 32'd1);
      if (first_v < 0 && a_tvalid) first_v = c;
      a_ce = 1'b1;
      a_data = 10'(c / 4 + 1);
      step();
    end
    check("adc_clk_pattern", 32'(pat), 32'hCC);
    check("first_tvalid_cycle", 32'(first_v), 32'd6);
    check("ramp_count", 32'(a_q.size()), 32'd4);
    check("ramp_w0", a_word(0), pk(0, 0, 16'h0040));
    check("ramp_w1", a_word(1), pk(1, 1, 16'h0080));
    check("ramp_w2", a_word(2), pk(0, 0, 16'h00C0));
    check("ramp_w3", a_word(3), pk(1, 1, 16'h0100));

    // Overflow with tready=0
    reset_a();
    for (int c = 0; c < 73; c++) begin
      if (c == 69) begin
        check("ovf_level_full", 32'(a_level), 32'd17);
        check("ovf_before_drop", 32'(a_ovf), 32'd0);
      end
      if (c == 72) check("ovf_still_clear", 32'(a_ovf), 32'd0);
      a_ce = 1'b1;
      a_data = 10'(c / 4 + 1);
      step();
    end
    check("ovf_set_on_drop", 32'(a_ovf), 32'd1);
    check("ovf_level_held", 32'(a_level), 32'd17);
    a_ce = 1'b0;
    a_tready = 1'b1;
    wait_a(17, 120, "ovf_drain_count");
    step(); step(); step(); step();
    check("ovf_no_extra", 32'(a_q.size()), 32'd17);
    check("ovf_level_empty", 32'(a_level), 32'd0);
    for (int k = 0; k < 17; k++)
      check("ovf_word", a_word(k), pk(k % 2, (k % 2) == 1, 16'((k + 1) << 6)));
    check("ovf_sticky", 32'(a_ovf), 32'd1);
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    check("ovf_cleared", 32'(a_ovf), 32'd0);

    // ce pause mid-frame
    reset_a();
    for (int c = 0; c < 14; c++) begin
      a_ce = 1'b1;
      a_data = 10'(c / 4 + 1);
      step();
    end
    a_ce = 1'b0;
    a_tready = 1'b1;
    clk_seen = 1'b0;
    sel_bad = 1'b0;
    for (int p = 0; p < 10; p++) begin
      step();
      clk_seen |= a_adc_clk;
      sel_bad  |= (a_sel != 1'b1);
    end
    check("pause_adc_clk_low", 32'(clk_seen), 32'd0);
    check("pause_sel_held", 32'(sel_bad), 32'd0);
    check("pause_drained", 32'(a_q.size()), 32'd3);
    check("pause_level", 32'(a_level), 32'd0);
    check("pause_w0", a_word(0), pk(0, 0, 16'h0040));
    check("pause_w1", a_word(1), pk(1, 1, 16'h0080));
    check("pause_w2", a_word(2), pk(0, 0, 16'h00C0));
    a_ce = 1'b1;
    a_data = 10'd4;
    wait_a(5, 40, "resume_count");
    check("resume_w0", a_word(3), pk(1, 1, 16'h0100));
    check("resume_w1", a_word(4), pk(0, 0, 16'h0100));

    // Reset with 5 words buffered
    reset_a();
    lim = 0;
    while (a_level < 5'd5 && lim < 40) begin
      a_ce = 1'b1;
      a_data = 10'd7;
      step();
      lim++;
    end
    a_ce = 1'b0;
    check("prerst_level", 32'(a_level), 32'd5);
    check("prerst_tvalid", 32'(a_tvalid), 32'd1);
    a_rst = 1'b1;
    #1;
    check("midrst_tvalid",  32'(a_tvalid),  32'd0);
    check("midrst_tdata",   32'(a_tdata),   32'd0);
    check("midrst_tid",     32'(a_tid),     32'd0);
    check("midrst_tlast",   32'(a_tlast),   32'd0);
    check("midrst_tstrb",   32'(a_tstrb),   32'd0);
    check("midrst_level",   32'(a_level),   32'd0);
    check("midrst_adc_clk", 32'(a_adc_clk), 32'd0);
    check("midrst_sel",     32'(a_sel),     32'd0);
    step(); step();
    a_rst = 1'b0;
    a_q.delete();
    a_data = 10'h3A;
    a_ce = 1'b1;
    a_tready = 1'b1;
    wait_a(1, 30, "postrst_count");
    check("postrst_w0", a_word(0), pk(0, 0, 16'h0E80));

    // FILL=LSB, TWOS_COMP=1 formatting on instance B
    reset_b();
    b_tready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 6) begin
        check("fmt_tvalid", 32'(b_tvalid), 32'd1);
        check("fmt_tstrb", 32'(b_tstrb), 32'd3);
      end
      b_ce = 1'b1;
      b_data = (c < 4) ? 10'h000 : 10'h3FF;
      step();
    end
    check("fmt_w0", b_word(0), pk(0, 0, 16'hFE00));
    check("fmt_w1", b_word(1), pk(1, 0, 16'h01FF));
    check("fmt_w2", b_word(2), pk(2, 0, 16'h01FF));
    check("fmt_w3", b_word(3), pk(3, 1, 16'h01FF));

    // Random tready over 1000 samples
    reset_b();
    n = 0;
    cyc = 0;
    while (n < 1000 && cyc < 20000) begin
      while (b_q.size() > 0 && n < 1000) begin
        w = b_q.pop_front();
        check("rand_word", w, exp_b(n));
        n++;
      end
      b_ce = 1'b1;
      b_data = 10'(cyc / 4);
      b_tready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    check("rand_count", 32'(n), 32'd1000);
    check("rand_no_ovf", 32'(b_ovf), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
